wb_sdrc_arbiter: RTL

- Round-robin Wishbone arbiter that shares the single Wishbone slave port of the SDRAM controller among NUM_M masters, e.g. CPU, DMA and video fetch.
- Holds off all grants until sdr_init_done is high.
- Keeps a grant for the whole cycle: from the granted master's cyc rising until it falls.
- Watchdog aborts a cycle the controller never acknowledges and returns err to the master.

---
 rtl/wb_sdrc_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/wb_sdrc_arbiter.sv
// Round-robin Wishbone arbiter in front of the SDRAM controller slave port.
// The grant is held for a whole bus cycle, and a watchdog aborts cycles that are never acked.
module wb_sdrc_arbiter #(
    parameter int NUM_M   = 4,
    parameter int APP_AW  = 26,
    parameter int dw      = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    sdr_init_done,
    input  logic [NUM_M-1:0]        m_cyc_i,
    input  logic [NUM_M-1:0]        m_stb_i,
    input  logic [NUM_M-1:0]        m_we_i,
    input  logic [NUM_M-1:0]        m_cti_i,
    input  logic [NUM_M*APP_AW-1:0] m_addr_i,
    input  logic [NUM_M*dw-1:0]     m_dat_i,
    input  logic [NUM_M*dw/8-1:0]   m_sel_i,
    output logic [NUM_M-1:0]        m_ack_o,
    output logic [NUM_M-1:0]        m_err_o,
    output logic [dw-1:0]           m_dat_o,
    output logic [NUM_M-1:0]        gnt_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic                    s_cti_o,
    output logic [APP_AW-1:0]       s_addr_o,
    output logic [dw-1:0]           s_dat_o,
    output logic [dw/8-1:0]         s_sel_o,
    input  logic                    s_ack_i,
    input  logic [dw-1:0]           s_dat_i
);
    localparam int SW = dw / 8;
    localparam int LW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [NUM_M-1:0] gnt_q, gnt_d;
    logic [LW-1:0]    last_q, last_d;
    logic [TO_W-1:0]  wdog_q, wdog_d;
    logic [NUM_M-1:0] err_q, err_d;

    logic              busy;
    logic              gcyc, gstb;
    logic [LW-1:0]     win, cand;
    int                idx;
    logic              mx_we, mx_cti;
    logic [APP_AW-1:0] mx_addr;
    logic [dw-1:0]     mx_dat;
    logic [SW-1:0]     mx_sel;

    // Outputs are also held quiet during the reset cycle itself.
    assign busy = (state_q == S_BUSY) && !wb_rst_i;
    assign gcyc = |(gnt_q & m_cyc_i);
    assign gstb = |(gnt_q & m_cyc_i & m_stb_i);

    // Round-robin scan starting just after the last winner.
    always_comb begin
        win  = last_q;
        cand = '0;
        idx  = 0;
        for (int i = 1; i <= NUM_M; i++) begin
            idx  = (int'(last_q) + i) % NUM_M;
            cand = LW'(idx);
            if (win == last_q && cand != last_q && m_cyc_i[cand])
                win = cand;
        end
        if (win == last_q && !m_cyc_i[last_q])
            win = last_q;
    end

    always_comb begin
        mx_we   = 1'b0;
        mx_cti  = 1'b0;
        mx_addr = '0;
        mx_dat  = '0;
        mx_sel  = '0;
        for (int k = 0; k < NUM_M; k++) begin
            if (gnt_q[k]) begin
                mx_we   = m_we_i[k];
                mx_cti  = m_cti_i[k];
                mx_addr = m_addr_i[k*APP_AW +: APP_AW];
                mx_dat  = m_dat_i[k*dw +: dw];
                mx_sel  = m_sel_i[k*SW +: SW];
            end
        end
    end

    assign s_cyc_o  = busy & gcyc;
    assign s_stb_o  = busy & gstb;
    assign s_we_o   = busy & mx_we;
    assign s_cti_o  = busy & mx_cti;
    assign s_addr_o = busy ? mx_addr : '0;
    assign s_dat_o  = busy ? mx_dat : '0;
    assign s_sel_o  = busy ? mx_sel : '0;
    assign m_ack_o  = busy ? (gnt_q & {NUM_M{s_ack_i}}) : '0;
    assign m_err_o  = wb_rst_i ? '0 : err_q;
    assign gnt_o    = wb_rst_i ? '0 : gnt_q;
    assign m_dat_o  = s_dat_i;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        err_d   = '0;
        case (state_q)
            S_IDLE: begin
                wdog_d = '0;
                if (sdr_init_done && |m_cyc_i) begin
                    gnt_d   = NUM_M'(1) << win;
                    last_d  = win;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (!gcyc) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    wdog_d  = '0;
                end else if (gstb && !s_ack_i) begin
                    if (TIMEOUT != 0 && wdog_q == TO_W'(TIMEOUT - 1)) begin
                        err_d   = gnt_q;
                        state_d = S_DRAIN;
                        wdog_d  = '0;
                    end else begin
                        wdog_d = wdog_q + TO_W'(1);
                    end
                end else begin
                    wdog_d = '0;
                end
            end
            S_DRAIN: begin
                wdog_d = '0;
                if (!gcyc) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                wdog_d  = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            last_q  <= LW'(NUM_M - 1);
            wdog_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
        end
    end
endmodule
